pll_retune_ctrl: RTL and testbench

Runtime PLL retuning sequencer for the Cyclone V reconfigurable PLL. It accepts a complete counter set (N, M, optional fractional K, NUM_CLK output C counters) in one request and writes it to the PLL reconfiguration core through that core's Avalon-MM management port. It then starts reconfiguration, polls for completion, and waits for PLL lock. It sits between the system/video control logic and the `pll_reconfig` instance beside each reconfigurable PLL, generalising fixed-frequency PLL wrappers to any output count and runtime frequency changes.

---
 rtl/pll_retune_pkg.sv | 16 +
 rtl/pll_retune_ctrl_if.sv | 11 +
 rtl/pll_retune_avmm.sv | 45 ++++
 rtl/pll_retune_ctrl.sv | 142 ++++++++++++++
 tb/tb_pll_retune_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pll_retune_pkg.sv
// pll_retune_pkg: shared FSM states, reconfig register addresses and the C-word packer
package pll_retune_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_WR_N, S_WR_M, S_WR_K, S_WR_C, S_START, S_POLL, S_WAIT_LOCK
  } state_e;
  localparam logic [5:0] A_MODE = 6'd0;
  localparam logic [5:0] A_STATUS = 6'd1;
  localparam logic [5:0] A_START = 6'd2;
  localparam logic [5:0] A_N = 6'd3;
  localparam logic [5:0] A_M = 6'd4;
  localparam logic [5:0] A_C = 6'd5;
  localparam logic [5:0] A_K = 6'd7;
  function automatic logic [31:0] c_word(input logic [4:0] idx, input logic [17:0] c);
    return {9'b0, idx, c};
  endfunction
endpackage

// File: rtl/pll_retune_ctrl_if.sv
// pll_retune_ctrl_if: PLL reconfig Avalon-MM management bus; master drives address/read/write/writedata, slave returns readdata/waitrequest
interface pll_retune_ctrl_if;
  logic [5:0] mgmt_address;
  logic mgmt_read;
  logic mgmt_write;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic mgmt_waitrequest;
  modport master(output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata, input mgmt_readdata, mgmt_waitrequest);
  modport slave(input mgmt_address, mgmt_read, mgmt_write, mgmt_writedata, output mgmt_readdata, mgmt_waitrequest);
endinterface

// File: rtl/pll_retune_avmm.sv
// pll_retune_avmm: single-transfer Avalon master; cmd_valid/cmd_rd/cmd_addr/cmd_data in, xfer_done pulse and captured rdata out, m = mgmt bus master
module pll_retune_avmm (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_rd,
  input  logic [5:0]        cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              xfer_done,
  output logic [31:0]       rdata,
  pll_retune_ctrl_if.master m
);
  logic rd_q, wr_q, done_q, fire;
  logic [5:0] addr_q;
  logic [31:0] data_q, rdata_q;
  assign fire = (rd_q | wr_q) & ~m.mgmt_waitrequest;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= fire;
      if (fire) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else if (cmd_valid) begin
        rd_q <= cmd_rd;
        wr_q <= ~cmd_rd;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      if (fire && rd_q) rdata_q <= m.mgmt_readdata;
    end
  end
  assign m.mgmt_read = rd_q;
  assign m.mgmt_write = wr_q;
  assign m.mgmt_address = addr_q;
  assign m.mgmt_writedata = data_q;
  assign xfer_done = done_q;
  assign rdata = rdata_q;
endmodule

// File: rtl/pll_retune_ctrl.sv
// pll_retune_ctrl: PLL retune sequencer; req/cfg_* in, busy/done/error out, pll_locked in, mgmt Avalon master; PLL_RETUNE_FRAC_EN adds the K write
module pll_retune_ctrl
  import pll_retune_pkg::*;
#(
  parameter int NUM_CLK = 4,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [17:0]           cfg_n,
  input  logic [17:0]           cfg_m,
  input  logic [31:0]           cfg_k,
  input  logic [18*NUM_CLK-1:0] cfg_c,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  pll_locked,
  pll_retune_ctrl_if.master     mgmt
);
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [17:0] n_q, m_q, c_sel;
  logic [18*NUM_CLK-1:0] c_q;
  logic [31:0] cnt_q, cnt_d, rdata, cmd_data;
  logic [5:0] cmd_addr;
  logic [1:0] sync_q;
  logic lk_q, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic acc, xfer_done, cmd_valid, cmd_rd, unused;
  assign acc = state_q == S_IDLE && req;
  assign c_sel = 18'(c_q >> (18 * idx_d));
`ifdef PLL_RETUNE_FRAC_EN
  logic [31:0] k_q;
  always_ff @(posedge clk) begin
    if (rst) k_q <= '0;
    else if (acc) k_q <= cfg_k;
  end
  assign unused = ^rdata[31:1];
`else
  assign unused = ^{rdata[31:1], cfg_k};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      sync_q <= '0;
      lk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      n_q <= '0;
      m_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      sync_q <= {sync_q[0], pll_locked};
      lk_q <= state_q == S_WAIT_LOCK && sync_q[1];
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      if (acc) begin
        n_q <= cfg_n;
        m_q <= cfg_m;
        c_q <= cfg_c;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    cnt_d = state_q == S_WAIT_LOCK ? cnt_q + 32'd1 : '0;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_MODE;
        busy_d = 1'b1;
        idx_d = '0;
      end
      S_MODE: if (xfer_done) state_d = S_WR_N;
      S_WR_N: if (xfer_done) state_d = S_WR_M;
`ifdef PLL_RETUNE_FRAC_EN
      S_WR_M: if (xfer_done) state_d = S_WR_K;
      S_WR_K: if (xfer_done) state_d = S_WR_C;
`else
      S_WR_M: if (xfer_done) state_d = S_WR_C;
`endif
      S_WR_C: if (xfer_done) begin
        idx_d = idx_q + 5'd1;
        state_d = idx_q == 5'(NUM_CLK - 1) ? S_START : S_WR_C;
      end
      S_START: if (xfer_done) state_d = S_POLL;
      S_POLL: if (xfer_done && rdata[0]) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (sync_q[1] && lk_q) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (cnt_q == 32'(LOCK_TIMEOUT)) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
        err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign cmd_valid = xfer_done ? state_d != S_WAIT_LOCK : acc;
  assign cmd_rd = state_d == S_POLL;
  always_comb begin
    cmd_addr = '0;
    cmd_data = '0;
    case (state_d)
      S_MODE: begin cmd_addr = A_MODE; cmd_data = 32'd1; end
      S_WR_N: begin cmd_addr = A_N; cmd_data = {14'b0, n_q}; end
      S_WR_M: begin cmd_addr = A_M; cmd_data = {14'b0, m_q}; end
`ifdef PLL_RETUNE_FRAC_EN
      S_WR_K: begin cmd_addr = A_K; cmd_data = k_q; end
`endif
      S_WR_C: begin cmd_addr = A_C; cmd_data = c_word(idx_d, c_sel); end
      S_START: begin cmd_addr = A_START; cmd_data = 32'd1; end
      S_POLL: cmd_addr = A_STATUS;
      default: cmd_addr = '0;
    endcase
  end
  pll_retune_avmm u_avmm (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .xfer_done(xfer_done),
    .rdata(rdata),
    .m(mgmt)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
endmodule

// File: tb/tb_pll_retune_ctrl.sv
// tb_pll_retune_ctrl: scoreboard bench with randomized cfg, Avalon slave/PLL models and per-request expected transfer lists
module tb_pll_retune_ctrl;
  localparam int NC = 4;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, pll_locked = 1'b0;
  logic [17:0] cfg_n = '0, cfg_m = '0;
  logic [31:0] cfg_k = '0;
  logic [18*NC-1:0] cfg_c = '0;
  logic busy, done, error;
  pll_retune_ctrl_if bus();
  pll_retune_ctrl #(.NUM_CLK(NC), .LOCK_TIMEOUT(100)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .cfg_n(cfg_n),
    .cfg_m(cfg_m),
    .cfg_k(cfg_k),
    .cfg_c(cfg_c),
    .busy(busy),
    .done(done),
    .error(error),
    .pll_locked(pll_locked),
    .mgmt(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rd;
    logic [5:0] a;
    logic [31:0] d;
  } xfer_t;
  xfer_t exp_q[$];
  xfer_t mon_e;
  int evq[$];
  int checks = 0, errors = 0, cyc = 0;
  int poll_zeros = 0, lock_delay = -1, lock_cnt = -1, poll_cnt = 0, hold_cnt = 0;
  bit rnd_en = 0, stall_m = 0, prev_hold = 0;
  logic rnd_w = 1'b0;
  int n_done = 0, n_err = 0, n_status = 0, n_mwr = 0, n_mcyc = 0, ok_cyc = 0;
  logic p_r, p_w;
  logic [5:0] p_a;
  logic [31:0] p_d;
  assign bus.mgmt_readdata = {31'b0, poll_cnt >= poll_zeros};
  assign bus.mgmt_waitrequest = rnd_w | (stall_m && bus.mgmt_write && bus.mgmt_address == 6'd4 && hold_cnt < 3);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd_w <= rnd_en && $urandom_range(0, 2) == 0;
    if (req && !busy) begin
      poll_cnt <= 0;
      hold_cnt <= 0;
    end else begin
      if (bus.mgmt_read && !bus.mgmt_waitrequest && bus.mgmt_address == 6'd1) poll_cnt <= poll_cnt + 1;
      if (bus.mgmt_write && bus.mgmt_waitrequest && bus.mgmt_address == 6'd4) hold_cnt <= hold_cnt + 1;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      pll_locked = 1'b0;
      lock_cnt = -1;
    end else if (bus.mgmt_write && !bus.mgmt_waitrequest && bus.mgmt_address == 6'd2) begin
      pll_locked = 1'b0;
      lock_cnt = lock_delay;
    end else if (lock_cnt > 0) lock_cnt--;
    else if (lock_cnt == 0) begin
      pll_locked = 1'b1;
      lock_cnt = -1;
    end
  end
  always @(negedge clk) begin
    if (rst) prev_hold = 0;
    else begin
      if (prev_hold) chk("hold_stable", {p_r, p_w, p_a, p_d}, {bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata});
      prev_hold = (bus.mgmt_read | bus.mgmt_write) & bus.mgmt_waitrequest;
      p_r = bus.mgmt_read;
      p_w = bus.mgmt_write;
      p_a = bus.mgmt_address;
      p_d = bus.mgmt_writedata;
      if (bus.mgmt_write && bus.mgmt_address == 6'd4) n_mcyc++;
      if ((bus.mgmt_read | bus.mgmt_write) && !bus.mgmt_waitrequest) begin
        chk("rw_exclusive", bus.mgmt_read & bus.mgmt_write, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected: got addr %0d rd %0b, expected no transfer", bus.mgmt_address, bus.mgmt_read);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_addr", {bus.mgmt_read, bus.mgmt_address}, {mon_e.rd, mon_e.a});
          if (!mon_e.rd) chk("xfer_data", bus.mgmt_writedata, mon_e.d);
        end
        if (bus.mgmt_read && bus.mgmt_address == 6'd1) begin
          n_status++;
          if (bus.mgmt_readdata[0]) ok_cyc = cyc;
        end
        if (bus.mgmt_write && bus.mgmt_address == 6'd4) n_mwr++;
      end
      if (done | error) begin
        chk("busy_fall", busy, 0);
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL event_unexpected: got done %0b error %0b, expected none", done, error);
        end else chk("event_kind", {done, error}, evq.pop_front() == 2 ? 2'b01 : 2'b10);
        if (error) chk("timeout_cycles", cyc - ok_cyc, 103);
        n_done += int'(done);
        n_err += int'(error);
      end
    end
  end
  task automatic issue(input int pz, input int ld, input bit exp_err);
    logic [17:0] n, m;
    logic [31:0] k;
    logic [18*NC-1:0] c;
    n = 18'($urandom);
    m = 18'($urandom);
    k = $urandom;
    c = 72'({$urandom, $urandom, $urandom});
    @(negedge clk);
    cfg_n = n;
    cfg_m = m;
    cfg_k = k;
    cfg_c = c;
    poll_zeros = pz;
    lock_delay = ld;
    req = 1'b1;
    exp_q.push_back('{1'b0, 6'd0, 32'd1});
    exp_q.push_back('{1'b0, 6'd3, {14'b0, n}});
    exp_q.push_back('{1'b0, 6'd4, {14'b0, m}});
`ifdef PLL_RETUNE_FRAC_EN
    exp_q.push_back('{1'b0, 6'd7, k});
`endif
    for (int i = 0; i < NC; i++) exp_q.push_back('{1'b0, 6'd5, {9'b0, 5'(i), c[18*i +: 18]}});
    exp_q.push_back('{1'b0, 6'd2, 32'd1});
    for (int i = 0; i <= pz; i++) exp_q.push_back('{1'b1, 6'd1, 32'd0});
    evq.push_back(exp_err ? 2 : 1);
    @(negedge clk);
    req = 1'b0;
    chk("accept", {busy, bus.mgmt_write, bus.mgmt_address}, {1'b1, 1'b1, 6'd0});
  endtask
  task automatic wait_end(input string nm);
    int s, i;
    s = n_done + n_err;
    i = 0;
    while (n_done + n_err == s && i < 3000) begin
      @(negedge clk);
      i++;
    end
    repeat (5) @(negedge clk);
    chk({nm, "_events"}, n_done + n_err - s, 1);
    chk({nm, "_drain"}, exp_q.size() + evq.size(), 0);
  endtask
  initial begin
    int d0, e0, c0, w0, s0, i;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, error, bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata}, 0);
    rst = 1'b0;
    d0 = n_done;
    issue(0, 10, 0);
    wait_end("basic");
    chk("basic_done", n_done - d0, 1);
    stall_m = 1;
    c0 = n_mcyc;
    w0 = n_mwr;
    issue(0, 10, 0);
    wait_end("mstall");
    stall_m = 0;
    chk("m_strobe_cycles", n_mcyc - c0, 4);
    chk("m_writes", n_mwr - w0, 1);
    s0 = n_status;
    issue(3, 10, 0);
    wait_end("poll");
    chk("status_reads", n_status - s0, 4);
    d0 = n_done;
    e0 = n_err;
    issue(0, -1, 1);
    wait_end("timeout");
    chk("timeout_error", n_err - e0, 1);
    chk("timeout_no_done", n_done - d0, 0);
    d0 = n_done;
    issue(0, 10, 0);
    repeat (5) @(negedge clk);
    cfg_n = 18'($urandom);
    cfg_m = 18'($urandom);
    cfg_c = 72'({$urandom, $urandom, $urandom});
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_end("ignore_req");
    chk("ignore_single_done", n_done - d0, 1);
    issue(0, 10, 0);
    i = 0;
    while (!(bus.mgmt_write && bus.mgmt_address == 6'd5) && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("reach_wr_c", i < 200, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort", {busy, done, error, bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata}, 0);
    exp_q.delete();
    evq.delete();
    rst = 1'b0;
    e0 = n_done + n_err;
    repeat (3) @(negedge clk);
    chk("rst_no_event", n_done + n_err - e0, 0);
    issue(0, 10, 0);
    wait_end("after_rst");
    rnd_en = 1;
    for (int t = 0; t < 8; t++) begin
      issue($urandom_range(0, 3), $urandom_range(2, 30), 0);
      wait_end("random");
    end
    rnd_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
